// File: rtl/fmult_pkg.sv
// Shared constants and helpers for the pipelined fixed-point multiplier.
// Holds the pipeline-depth legality check, saturation bounds and lane slicing.
package fmult_pkg;

  localparam int PIPE_STAGES_MIN = 1;
  localparam int PIPE_STAGES_MAX = 4;

  function automatic bit pipe_stages_ok(input int p);
    return (p >= PIPE_STAGES_MIN) && (p <= PIPE_STAGES_MAX);
  endfunction

  // Saturation bounds of a signed two's-complement value of width w (w <= 64).
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/fmult_pipe_if.sv
// Handshake and data bundle of fmult_pipe; slave is the multiplier side,
// master the upstream/downstream side.
interface fmult_pipe_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int LANES      = 1
);

  logic                          i_valid;
  logic                          o_ready;
  logic [LANES*DIN_WIDTH-1:0]    i_multiplicand;
  logic [LANES*DIN_WIDTH-1:0]    i_multiplier;
  logic [LANES-1:0]              i_ovr;
  logic                          o_valid;
  logic                          i_ready;
  logic [LANES*DOUT_WIDTH-1:0]   o_result;
  logic [LANES-1:0]              o_ovr;
  logic                          i_clr_ovr;
  logic                          o_ovr_sticky;

  modport slave (
    input  i_valid, i_multiplicand, i_multiplier, i_ovr, i_ready, i_clr_ovr,
    output o_ready, o_valid, o_result, o_ovr, o_ovr_sticky
  );

  modport master (
    output i_valid, i_multiplicand, i_multiplier, i_ovr, i_ready, i_clr_ovr,
    input  o_ready, o_valid, o_result, o_ovr, o_ovr_sticky
  );

endinterface

// File: rtl/fmult_round_sat.sv
// Per-lane conversion of a full-precision product to the output format.
// Macro FMULT_PIPE_ROUND_EN selects round-half-up instead of floor truncation.
module fmult_round_sat
  import fmult_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_FRAC   = 15,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 15
) (
  input  logic signed [2*DIN_WIDTH-1:0] i_prod,
  output logic signed [DOUT_WIDTH-1:0]  o_result,
  output logic                          o_ovr
);

  localparam int SH = 2*DIN_FRAC - DOUT_FRAC;
  // One guard bit above the product so the rounding add cannot wrap.
  localparam int EW = (2*DIN_WIDTH + 1 > DOUT_WIDTH + 1) ? 2*DIN_WIDTH + 1 : DOUT_WIDTH + 1;
  localparam longint MAX64 = sat_max(DOUT_WIDTH);
  localparam longint MIN64 = sat_min(DOUT_WIDTH);
  localparam logic signed [EW-1:0] MAXV = MAX64[EW-1:0];
  localparam logic signed [EW-1:0] MINV = MIN64[EW-1:0];

  if (SH < 0) begin : g_bad_frac
    $error("fmult_round_sat: DOUT_FRAC must not exceed 2*DIN_FRAC");
  end

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_shr;

  assign w_ext = EW'(i_prod);

`ifdef FMULT_PIPE_ROUND_EN
  if (SH > 0) begin : g_round
    localparam logic signed [EW-1:0] HALF = EW'(1) <<< (SH - 1);
    assign w_rnd = w_ext + HALF;
  end else begin : g_no_round
    assign w_rnd = w_ext;
  end
`else
  assign w_rnd = w_ext;
`endif

  assign w_shr = w_rnd >>> SH;

  always_comb begin
    o_ovr    = 1'b0;
    o_result = w_shr[DOUT_WIDTH-1:0];
    if (w_shr > MAXV) begin
      o_result = MAXV[DOUT_WIDTH-1:0];
      o_ovr    = 1'b1;
    end else if (w_shr < MINV) begin
      o_result = MINV[DOUT_WIDTH-1:0];
      o_ovr    = 1'b1;
    end
  end

endmodule

// File: rtl/fmult_pipe.sv
// Pipelined multi-lane signed fixed-point multiplier with saturation and sticky
// overflow status. Build option: FMULT_PIPE_ROUND_EN (round-half-up conversion).
module fmult_pipe
  import fmult_pkg::*;
#(
  parameter int DIN_WIDTH   = 16,
  parameter int DIN_FRAC    = 15,
  parameter int DOUT_WIDTH  = 16,
  parameter int DOUT_FRAC   = 15,
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fmult_pipe_if.slave bus
);

  localparam int PW = 2*DIN_WIDTH;

  if (!pipe_stages_ok(PIPE_STAGES)) begin : g_bad_depth
    $error("fmult_pipe: PIPE_STAGES out of range 1..4");
  end

  // Handshake: a global advance w_adv = !o_valid | i_ready moves every stage at
  // once. Input transfers on i_valid & o_ready (o_ready == w_adv), output on
  // o_valid & i_ready; with w_adv low all stages hold, bubbles are kept.
  logic                         w_adv;
  logic [PIPE_STAGES-1:0]       r_vld;
  logic [LANES-1:0][PW-1:0]     w_prod;
  logic [LANES-1:0][PW-1:0]     w_conv_in;
  logic [LANES-1:0]             w_conv_ovr_in;
  logic [LANES-1:0]             w_sat_ovr;
  logic [LANES*DOUT_WIDTH-1:0]  w_res_pk;
  logic [LANES*DOUT_WIDTH-1:0]  r_result;
  logic [LANES-1:0]             r_ovr;
  logic                         r_sticky;

  assign w_adv = !r_vld[PIPE_STAGES-1] | bus.i_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DIN_WIDTH-1:0]  w_a;
    logic signed [DIN_WIDTH-1:0]  w_b;
    logic signed [DOUT_WIDTH-1:0] w_res;

    assign w_a       = bus.i_multiplicand[lane_lsb(k, DIN_WIDTH) +: DIN_WIDTH];
    assign w_b       = bus.i_multiplier[lane_lsb(k, DIN_WIDTH) +: DIN_WIDTH];
    assign w_prod[k] = PW'(w_a) * PW'(w_b);

    fmult_round_sat #(
      .DIN_WIDTH (DIN_WIDTH),
      .DIN_FRAC  (DIN_FRAC),
      .DOUT_WIDTH(DOUT_WIDTH),
      .DOUT_FRAC (DOUT_FRAC)
    ) u_round_sat (
      .i_prod  (w_conv_in[k]),
      .o_result(w_res),
      .o_ovr   (w_sat_ovr[k])
    );

    assign w_res_pk[lane_lsb(k, DOUT_WIDTH) +: DOUT_WIDTH] = w_res;
  end

  if (PIPE_STAGES == 1) begin : g_direct
    assign w_conv_in     = w_prod;
    assign w_conv_ovr_in = bus.i_ovr;
  end else begin : g_prod_pipe
    // Stage 1 holds the full product; any further stages before the last are delay.
    logic [PIPE_STAGES-2:0][LANES-1:0][PW-1:0] r_prod;
    logic [PIPE_STAGES-2:0][LANES-1:0]         r_povr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_prod <= '0;
        r_povr <= '0;
      end else if (w_adv) begin
        r_prod[0] <= w_prod;
        r_povr[0] <= bus.i_ovr;
        for (int s = 1; s < PIPE_STAGES - 1; s++) begin
          r_prod[s] <= r_prod[s-1];
          r_povr[s] <= r_povr[s-1];
        end
      end
    end

    assign w_conv_in     = r_prod[PIPE_STAGES-2];
    assign w_conv_ovr_in = r_povr[PIPE_STAGES-2];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld    <= '0;
      r_result <= '0;
      r_ovr    <= '0;
    end else if (w_adv) begin
      r_vld[0] <= bus.i_valid;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      r_result <= w_res_pk;
      r_ovr    <= w_conv_ovr_in | w_sat_ovr;
    end
  end

  // A set on the delivering cycle takes priority over a coincident clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_vld[PIPE_STAGES-1] & bus.i_ready & (|r_ovr)) begin
      r_sticky <= 1'b1;
    end else if (bus.i_clr_ovr) begin
      r_sticky <= 1'b0;
    end
  end

  assign bus.o_ready      = w_adv;
  assign bus.o_valid      = r_vld[PIPE_STAGES-1];
  assign bus.o_result     = r_result;
  assign bus.o_ovr        = r_ovr;
  assign bus.o_ovr_sticky = r_sticky;

endmodule

// File: tb/tb_fmult_pipe.sv
// Bench for fmult_pipe: a Q1.15 single-lane instance driven by random and directed
// traffic against an arithmetic reference model, plus a 4-lane, 3-stage instance.
module tb_fmult_pipe;

  localparam int DW  = 16;
  localparam int FR  = 15;
  localparam int OW  = 16;
  localparam int OF  = 15;
  localparam int SH  = 2*FR - OF;
  localparam int P   = 2;
  localparam int L4  = 4;
  localparam int P4  = 3;
  localparam int EXW = OW + 1;

  logic clk;
  logic rst_n;
  int   cyc;

  fmult_pipe_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LANES(1))  bus  ();
  fmult_pipe_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LANES(L4)) bus4 ();

  fmult_pipe #(
    .DIN_WIDTH(DW), .DIN_FRAC(FR), .DOUT_WIDTH(OW), .DOUT_FRAC(OF),
    .LANES(1), .PIPE_STAGES(P)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  fmult_pipe #(
    .DIN_WIDTH(DW), .DIN_FRAC(FR), .DOUT_WIDTH(OW), .DOUT_FRAC(OF),
    .LANES(L4), .PIPE_STAGES(P4)
  ) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [EXW-1:0] exp_q[$];
  int             acc_q[$];
  logic           exp_sticky = 1'b0;
  logic           run_mon = 1'b0;
  logic           chk_lat = 1'b0;
  logic           held = 1'b0;
  logic [OW-1:0]  held_res;
  logic           held_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, optional half-LSB bias, floor shift, clamp.
  function automatic logic [EXW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic ov);
    longint p, q, mx, mn;
    logic   o;
    logic [EXW-1:0] r;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef FMULT_PIPE_ROUND_EN
    if (SH > 0) p = p + (longint'(1) <<< (SH - 1));
`endif
    q  = p >>> SH;
    mx = (longint'(1) <<< (OW - 1)) - 1;
    mn = -(longint'(1) <<< (OW - 1));
    o  = ov;
    if (q > mx) begin
      q = mx; o = 1'b1;
    end else if (q < mn) begin
      q = mn; o = 1'b1;
    end
    r = {o, q[OW-1:0]};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ov);
    bit done = 0;
    bus.i_valid        = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    bus.i_ovr          = ov;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        exp_q.push_back(model(a, b, ov));
        acc_q.push_back(cyc);
        done = 1;
      end
      @(posedge clk); #1;
    end
    check("send_accepted", done, 1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EXW-1:0] e;
    int             a;
    logic           xfer_ovr;
    if (rst_n && run_mon) begin
      xfer_ovr = 1'b0;
      check("sticky", bus.o_ovr_sticky, exp_sticky);
      check("o_ready", bus.o_ready, !bus.o_valid || bus.i_ready);
      if (held) begin
        check("stall_valid", bus.o_valid, 1);
        check("stall_result", bus.o_result, held_res);
        check("stall_ovr", bus.o_ovr, held_ovr);
      end
      if (bus.o_valid && bus.i_ready) begin
        check("expected_output", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", bus.o_result, e[OW-1:0]);
          check("ovr", bus.o_ovr, e[OW]);
          if (chk_lat) check("latency", cyc - a, P);
          xfer_ovr = e[OW];
        end
      end
      held     = bus.o_valid && !bus.i_ready;
      held_res = bus.o_result;
      held_ovr = bus.o_ovr;
      if (xfer_ovr)           exp_sticky = 1'b1;
      else if (bus.i_clr_ovr) exp_sticky = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat4;
    logic [EXW-1:0] e4;
    logic [3:0] ovr4;
    logic [L4*DW-1:0] a4, b4;
    rst_n = 1'b0;
    bus.i_valid = 0; bus.i_multiplicand = '0; bus.i_multiplier = '0; bus.i_ovr = '0;
    bus.i_ready = 1; bus.i_clr_ovr = 0;
    bus4.i_valid = 0; bus4.i_multiplicand = '0; bus4.i_multiplier = '0; bus4.i_ovr = '0;
    bus4.i_ready = 1; bus4.i_clr_ovr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.o_valid, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_ovr", bus.o_ovr, 0);
    check("rst_sticky", bus.o_ovr_sticky, 0);
    check("rst4_valid", bus4.o_valid, 0);
    rst_n = 1'b1;
    run_mon = 1'b1;
    @(posedge clk); #1;

    // Basic multiply and latency
    chk_lat = 1;
    send(16'h4000, 16'h4000, 0);
    drain();

    // Saturation, sticky set, clear, and clear coincident with a new overflow
    send(16'h8000, 16'h8000, 0);
    drain();
    bus.i_clr_ovr = 1; @(posedge clk); #1;
    bus.i_clr_ovr = 0; repeat (2) @(posedge clk); #1;
    bus.i_clr_ovr = 1;
    send(16'h8000, 16'h8000, 0);
    drain();
    bus.i_clr_ovr = 0;
    send(16'h0000, 16'h1234, 1);
    send(16'h7FFF, 16'h7FFF, 0);
    drain();

    // Rounding boundary pairs
    send(16'h0001, 16'h4000, 0);
    send(16'hFFFF, 16'h4000, 0);
    drain();

    // Back-pressure: ready pattern 1,0,0 repeating while 8 items stream in
    chk_lat = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bus.i_ready = (i % 3 == 0);
          @(posedge clk); #1;
        end
        bus.i_ready = 1;
      end
      begin
        for (int i = 0; i < 8; i++)
          send(DW'($urandom_range(0, 16'hFFFF)), DW'($urandom_range(0, 16'hFFFF)), 0);
      end
    join
    drain();

    // Random traffic with random ready, gaps, upstream flags and clears
    begin
      bit stop = 0;
      fork
        begin
          for (int i = 0; i < 3000 && !stop; i++) begin
            bus.i_ready   = ($urandom_range(0, 3) != 0);
            bus.i_clr_ovr = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
          end
          bus.i_ready = 1; bus.i_clr_ovr = 0;
        end
        begin
          for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(DW'($urandom_range(0, 16'hFFFF)), DW'($urandom_range(0, 16'hFFFF)),
                 ($urandom_range(0, 7) == 0));
          end
          stop = 1;
        end
      join
    end
    drain();

    // Four lanes, three stages
    a4 = {16'h0000, 16'h7FFF, 16'h8000, 16'h4000};
    b4 = {16'h0000, 16'h7FFF, 16'h8000, 16'h4000};
    bus4.i_multiplicand = a4;
    bus4.i_multiplier   = b4;
    bus4.i_ovr          = 4'b1000;
    bus4.i_valid        = 1;
    @(negedge clk);
    check("l4_ready", bus4.o_ready, 1);
    lat4 = cyc;
    @(posedge clk); #1;
    bus4.i_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.o_valid) break;
    end
    check("l4_valid", bus4.o_valid, 1);
    check("l4_latency", cyc - lat4, P4);
    ovr4 = '0;
    for (int k = 0; k < L4; k++) begin
      e4 = model(a4[k*DW +: DW], b4[k*DW +: DW], (k == 3));
      check($sformatf("l4_result%0d", k), bus4.o_result[k*OW +: OW], e4[OW-1:0]);
      ovr4[k] = e4[OW];
    end
    check("l4_ovr_model", bus4.o_ovr, ovr4);
    check("l4_ovr_const", bus4.o_ovr, 4'b1010);
    check("l4_result0_const", bus4.o_result[0 +: OW], 16'h2000);
    @(negedge clk);
    check("l4_sticky", bus4.o_ovr_sticky, 1);
    check("l4_drained", bus4.o_valid, 0);
    @(posedge clk); #1;

    // Reset with two items in flight
    chk_lat = 1;
    send(16'h4000, 16'h2000, 0);
    send(16'h8000, 16'h8000, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    held = 0;
    exp_sticky = 0;
    #1;
    check("mid_rst_valid", bus.o_valid, 0);
    check("mid_rst_result", bus.o_result, 0);
    check("mid_rst_ovr", bus.o_ovr, 0);
    check("mid_rst_sticky", bus.o_ovr_sticky, 0);
    check("mid_rst4_sticky", bus4.o_ovr_sticky, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    send(16'hC000, 16'h4000, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fmult_pipe.md
Name: fmult_pipe

Overview:
Pipelined, multi-lane signed fixed-point multiplier with a valid/ready handshake.
- Generalises the combinational fractional multiplier used in the adaptive-filter datapath: parametrised lane count and pipeline depth, saturating conversion to the output format, overflow-flag propagation, and a sticky overflow status.
- Sits between the tap-weight/sample registers and the accumulator in the filter and LMS-update paths.

Parameters:
- DIN_WIDTH, 16, input operand width per lane
- DIN_FRAC, 15, input fractional bits
- DOUT_WIDTH, 16, output width per lane
- DOUT_FRAC, 15, output fractional bits; must satisfy DOUT_FRAC <= 2*DIN_FRAC
- LANES, 1, independent multiplier lanes sharing one handshake
- PIPE_STAGES, 2, register stages from input to output; legal range 1..4

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input operands valid
- o_ready  out  1  block accepts input this cycle
- i_multiplicand  in  LANES*DIN_WIDTH  lane k at [k*DIN_WIDTH +: DIN_WIDTH], signed
- i_multiplier  in  LANES*DIN_WIDTH  same packing, signed
- i_ovr  in  LANES  upstream overflow flag per lane
- o_valid  out  1  output valid
- i_ready  in  1  downstream accepts output
- o_result  out  LANES*DOUT_WIDTH  lane k at [k*DOUT_WIDTH +: DOUT_WIDTH], signed
- o_ovr  out  LANES  per-lane overflow, aligned with o_result
- i_clr_ovr  in  1  synchronous clear of sticky status
- o_ovr_sticky  out  1  OR of every o_ovr delivered since reset or clear

Behaviour:
- Reset: clocking and reset polarity are fixed as follows.
  - One clock, i_clk; reset i_rst_n is asynchronous, active-low.
  - While in reset: all stage valid bits, data and flag registers, o_valid, o_result, o_ovr and o_ovr_sticky are 0.
  - Asserting reset mid-operation discards in-flight data. First valid output appears PIPE_STAGES cycles after the first accepted input following release.
- Handshake: the pipeline advances on a global enable, adv = !o_valid | i_ready.
  - o_ready = adv.
  - A transfer in occurs on i_valid & o_ready; a transfer out occurs on o_valid & i_ready.
  - On a stall (adv=0), every stage holds its data, flags and valid.
  - Bubbles are not collapsed.
  - Full throughput is 1 result/cycle when i_ready=1.
- Latency: exactly PIPE_STAGES cycles from acceptance to o_valid when not stalled.
- Stage placement:
  - PIPE_STAGES=1: multiply and convert are combinational into one output register.
  - PIPE_STAGES>=2: stage 1 registers the full product (2*DIN_WIDTH bits, 2*DIN_FRAC frac) plus i_ovr; the last stage registers the converted result; intermediate stages are pure delay.
- Conversion, per lane:
  - SH = 2*DIN_FRAC - DOUT_FRAC.
  - Arithmetic right shift by SH, i.e. truncation toward minus infinity.
  - Integer part is saturated to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; a clamp sets the lane's conversion-overflow flag.
- Overflow flags:
  - o_ovr[k] = delayed i_ovr[k] | conversion overflow of lane k.
  - When i_ovr[k]=1, the data is still converted and output normally; the flag only propagates.
- Sticky status:
  - o_ovr_sticky sets on any transfer out with |o_ovr.
  - i_clr_ovr clears it.
  - If a clear and a set occur in the same cycle, the set wins (sticky=1).
- Boundaries:
  - -1.0 * -1.0 in Q1.15 saturates to 0x7FFF with ovr=1.
  - Output held stable while o_valid & !i_ready.
  - i_valid while o_ready=0 is ignored; upstream must hold it.

Optional Feature:
FMULT_PIPE_ROUND_EN
- Defined: round-half-up before the shift. Add 2^(SH-1) to the full product, then shift and saturate. Applies only when SH>0.
- Undefined: plain truncation, no adder in the datapath.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fmult_pkg: PIPE_STAGES legality check constant, the saturation max/min function of width, and a lane-slicing helper function.
- One natural sub-module: fmult_round_sat. It is per-lane, combinational, and takes the full product to the result plus overflow, including the macro-controlled rounding. It is instantiated LANES times.
- Pipeline registers and the handshake stay in fmult_pipe.

Test Plan:
All scenarios use defaults (Q1.15, PIPE_STAGES=2) unless stated.
1. Basic multiply: 0x4000*0x4000, i_ready=1 -> o_result=0x2000, o_ovr=0, o_valid exactly 2 cycles after acceptance.
2. Saturation: 0x8000*0x8000 -> o_result=0x7FFF, o_ovr=1, o_ovr_sticky=1 next cycle. Then i_clr_ovr pulse -> sticky=0. Clear coincident with a new ovr transfer -> sticky stays 1.
3. Rounding with operands 0x0001*0x4000 and 0xFFFF*0x4000:
   - Macro undefined -> 0x0000 and 0xFFFF.
   - Macro defined -> 0x0001 and 0x0000.
4. Back-pressure: stream 8 operand pairs with i_ready toggling 1,0,0,1,... -> o_ready mirrors the stall. All 8 results appear in order with no loss or duplication, and o_result is stable while stalled.
5. Multi-lane with LANES=4, PIPE_STAGES=3, lanes (0x4000*0x4000, 0x8000*0x8000, 0x7FFF*0x7FFF, i_ovr=1 on 0x0000*0x0000) -> results 0x2000, 0x7FFF, 0x7FFE, 0x0000 with o_ovr=4'b1010, latency 3.
6. Reset mid-flight: assert i_rst_n=0 with 2 items in flight -> o_valid=0 immediately (asynchronously), no stale output after release, next accepted input returns after PIPE_STAGES cycles.
